// File: rtl/dbg_axil_pkg.sv
`default_nettype none
// dbg_axil_pkg: FSM state type, AXI response codes and fixed channel values for dbg_axil_master.
// Revision 1.0
package dbg_axil_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_EXOKAY = 2'b01;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  localparam logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF;
  localparam logic [3:0]  WSTRB_ALL   = 4'hF;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dbg_axil_master.sv
`default_nettype none
// dbg_axil_master: single-beat debug command to AXI4-Lite master bridge, one transaction at a time.
// Optional sticky response-error flag with DBG_AXIL_RESP_ERR_EN. Revision 1.0
module dbg_axil_master
  import dbg_axil_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       axi_addr,
  input  logic [DATA_W-1:0] axi_data_in,
  input  logic              axi_wr,
  input  logic              axi_rd,
  output logic              axi_busy,
  output logic [DATA_W-1:0] axi_data_out,
`ifdef DBG_AXIL_RESP_ERR_EN
  output logic              resp_err,
  input  logic              resp_err_clr,
`endif
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [2:0]        m_awprot,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [2:0]        m_arprot,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready
);

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                aw_done;
  logic                w_done;
  logic                aw_hs;
  logic                w_hs;

  assign aw_hs = m_awvalid && m_awready;
  assign w_hs  = m_wvalid && m_wready;

  // Combinational so the host sees busy in its own pulse cycle.
  assign axi_busy = (state != IDLE) || axi_wr || axi_rd;

  assign m_awaddr = addr_q;
  assign m_araddr = addr_q;
  assign m_wdata  = wdata_q;
  assign m_wstrb  = WSTRB_ALL;
  assign m_awprot = 3'b000;
  assign m_arprot = 3'b000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      axi_data_out <= '0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      m_awvalid    <= 1'b0;
      m_wvalid     <= 1'b0;
      m_bready     <= 1'b0;
      m_arvalid    <= 1'b0;
      m_rready     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A simultaneous read pulse is dropped in favour of the write.
          if (axi_wr) begin
            addr_q    <= axi_addr[ADDR_W-1:0];
            wdata_q   <= axi_data_in;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            m_awvalid <= 1'b1;
            m_wvalid  <= 1'b1;
            state     <= WR_REQ;
          end else if (axi_rd) begin
            addr_q    <= axi_addr[ADDR_W-1:0];
            m_arvalid <= 1'b1;
            state     <= RD_REQ;
          end
        end
        WR_REQ: begin
          if (aw_hs) begin
            m_awvalid <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            m_wvalid <= 1'b0;
            w_done   <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            m_bready <= 1'b1;
            state    <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_bvalid) begin
            m_bready <= 1'b0;
            state    <= IDLE;
          end
        end
        RD_REQ: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (m_rvalid) begin
`ifdef DBG_AXIL_RESP_ERR_EN
            axi_data_out <= resp_is_err(m_rresp) ? ERR_RDATA : m_rdata;
`else
            axi_data_out <= m_rdata;
`endif
            m_rready <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DBG_AXIL_RESP_ERR_EN
  // Set has priority over a coincident clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_err <= 1'b0;
    end else if ((m_bready && m_bvalid && resp_is_err(m_bresp)) ||
                 (m_rready && m_rvalid && resp_is_err(m_rresp))) begin
      resp_err <= 1'b1;
    end else if (resp_err_clr) begin
      resp_err <= 1'b0;
    end
  end
`else
  logic unused_resp;
  assign unused_resp = ^{m_bresp, m_rresp};
`endif

endmodule
`default_nettype wire

// File: tb/tb_dbg_axil_master.sv
`default_nettype none
// tb_dbg_axil_master: directed self-checking bench for dbg_axil_master.
module tb_dbg_axil_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] axi_addr = '0;
  logic [31:0] axi_data_in = '0;
  logic        axi_wr = 1'b0;
  logic        axi_rd = 1'b0;
  logic        axi_busy;
  logic [31:0] axi_data_out;
  logic        resp_err;
  logic        resp_err_clr = 1'b0;
  logic [31:0] m_awaddr;
  logic [2:0]  m_awprot;
  logic        m_awvalid;
  logic        m_awready = 1'b0;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready = 1'b0;
  logic [1:0]  m_bresp = 2'b00;
  logic        m_bvalid = 1'b0;
  logic        m_bready;
  logic [31:0] m_araddr;
  logic [2:0]  m_arprot;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = 2'b00;
  logic        m_rvalid = 1'b0;
  logic        m_rready;

  int errors = 0;
  int checks = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0;

  dbg_axil_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .axi_addr(axi_addr), .axi_data_in(axi_data_in),
    .axi_wr(axi_wr), .axi_rd(axi_rd),
    .axi_busy(axi_busy), .axi_data_out(axi_data_out),
`ifdef DBG_AXIL_RESP_ERR_EN
    .resp_err(resp_err), .resp_err_clr(resp_err_clr),
`endif
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

`ifndef DBG_AXIL_RESP_ERR_EN
  assign resp_err = 1'b0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_awvalid && m_awready) aw_cnt++;
    if (m_wvalid && m_wready)   w_cnt++;
    if (m_bready && m_bvalid)   b_cnt++;
    if (m_arvalid)              ar_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (axi_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", axi_busy); end
    checks++; if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 5'b0) begin
      errors++; $display("FAIL reset_handshake got=%b exp=00000", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}); end
    checks++; if ({m_awaddr, m_wdata, axi_data_out} !== 96'h0) begin
      errors++; $display("FAIL reset_regs awaddr=%h wdata=%h dout=%h exp=0", m_awaddr, m_wdata, axi_data_out); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_write_basic();
    m_awready = 1; m_wready = 1; m_bvalid = 1; m_bresp = 2'b00;
    tick();
    axi_addr = 32'h4000_0010; axi_data_in = 32'h1234_5678; axi_wr = 1;
    #1;
    checks++; if (axi_busy !== 1'b1) begin errors++; $display("FAIL wr_busy_C got=%b exp=1", axi_busy); end
    checks++; if (m_awvalid !== 1'b0) begin errors++; $display("FAIL wr_awvalid_C got=%b exp=0", m_awvalid); end
    tick(); axi_wr = 0; #1;
    checks++; if ({m_awvalid, m_wvalid} !== 2'b11) begin errors++; $display("FAIL wr_valids_C1 got=%b exp=11", {m_awvalid, m_wvalid}); end
    checks++; if (m_awaddr !== 32'h4000_0010 || m_wdata !== 32'h1234_5678) begin
      errors++; $display("FAIL wr_payload got=%h/%h exp=40000010/12345678", m_awaddr, m_wdata); end
    checks++; if (m_wstrb !== 4'hF || m_awprot !== 3'b000) begin
      errors++; $display("FAIL wr_strb_prot got=%h/%b exp=f/000", m_wstrb, m_awprot); end
    checks++; if (axi_busy !== 1'b1) begin errors++; $display("FAIL wr_busy_C1 got=%b exp=1", axi_busy); end
    tick(); #1;
    checks++; if ({m_awvalid, m_wvalid, m_bready, axi_busy} !== 4'b0011) begin
      errors++; $display("FAIL wr_C2 aw,w,bready,busy got=%b exp=0011", {m_awvalid, m_wvalid, m_bready, axi_busy}); end
    tick(); #1;
    checks++; if ({m_bready, axi_busy} !== 2'b00) begin errors++; $display("FAIL wr_C3 bready,busy got=%b exp=00", {m_bready, axi_busy}); end
    m_bvalid = 0;
  endtask

  task automatic test_write_stall();
    m_awready = 1; m_wready = 0; m_bvalid = 0;
    tick();
    axi_addr = 32'h4000_0020; axi_data_in = 32'hA5A5_0F0F; axi_wr = 1;
    tick(); axi_wr = 0; #1;
    checks++; if ({m_awvalid, m_wvalid} !== 2'b11) begin errors++; $display("FAIL st_valids got=%b exp=11", {m_awvalid, m_wvalid}); end
    tick(); m_awready = 0; #1;
    checks++; if ({m_awvalid, m_wvalid, m_bready} !== 3'b010) begin
      errors++; $display("FAIL st_after_aw aw,w,bready got=%b exp=010", {m_awvalid, m_wvalid, m_bready}); end
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      checks++; if ({m_awvalid, m_wvalid, m_bready} !== 3'b010 || m_wdata !== 32'hA5A5_0F0F) begin
        errors++; $display("FAIL st_hold_%0d aw,w,bready=%b wdata=%h exp=010/a5a50f0f", i, {m_awvalid, m_wvalid, m_bready}, m_wdata); end
    end
    m_wready = 1;
    tick(); m_wready = 0; #1;
    checks++; if ({m_wvalid, m_bready, axi_busy} !== 3'b011) begin
      errors++; $display("FAIL st_after_w w,bready,busy got=%b exp=011", {m_wvalid, m_bready, axi_busy}); end
    m_bvalid = 1;
    tick(); m_bvalid = 0; #1;
    checks++; if ({m_bready, axi_busy} !== 2'b00) begin errors++; $display("FAIL st_done bready,busy got=%b exp=00", {m_bready, axi_busy}); end
  endtask

  task automatic test_read();
    m_arready = 1; m_rvalid = 0; m_rdata = 32'hCAFE_F00D; m_rresp = 2'b00;
    tick();
    axi_addr = 32'h0000_0004; axi_rd = 1;
    tick(); axi_rd = 0; #1;
    checks++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h4 || m_arprot !== 3'b000) begin
      errors++; $display("FAIL rd_ar valid=%b addr=%h prot=%b exp=1/4/000", m_arvalid, m_araddr, m_arprot); end
    tick(); #1;
    checks++; if ({m_arvalid, m_rready} !== 2'b01) begin errors++; $display("FAIL rd_after_ar got=%b exp=01", {m_arvalid, m_rready}); end
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      checks++; if (axi_busy !== 1'b1) begin errors++; $display("FAIL rd_wait_busy_%0d got=%b exp=1", i, axi_busy); end
    end
    tick(); m_rvalid = 1;
    tick(); m_rvalid = 0; m_rdata = 32'h0BAD_0BAD; #1;
    checks++; if ({axi_busy, m_rready} !== 2'b00 || axi_data_out !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL rd_done busy,rready=%b dout=%h exp=00/cafef00d", {axi_busy, m_rready}, axi_data_out); end
    for (int i = 0; i < 20; i++) begin
      tick(); #1;
      checks++; if (axi_data_out !== 32'hCAFE_F00D) begin errors++; $display("FAIL rd_hold_%0d got=%h exp=cafef00d", i, axi_data_out); end
    end
  endtask

  task automatic test_wr_rd_same();
    m_awready = 1; m_wready = 1; m_bvalid = 1; m_arready = 1; m_rvalid = 1; m_rdata = 32'h1111_1111;
    tick();
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0;
    axi_addr = 32'h0000_0010; axi_data_in = 32'h7777_7777; axi_wr = 1; axi_rd = 1;
    tick(); axi_wr = 0; axi_rd = 0;
    repeat (5) tick();
    #1;
    checks++; if (aw_cnt !== 1 || w_cnt !== 1 || b_cnt !== 1) begin
      errors++; $display("FAIL same_wr_count aw=%0d w=%0d b=%0d exp=1/1/1", aw_cnt, w_cnt, b_cnt); end
    checks++; if (ar_cnt !== 0) begin errors++; $display("FAIL same_no_ar got=%0d exp=0", ar_cnt); end
    checks++; if (axi_data_out !== 32'hCAFE_F00D || axi_busy !== 1'b0) begin
      errors++; $display("FAIL same_idle dout=%h busy=%b exp=cafef00d/0", axi_data_out, axi_busy); end
    m_bvalid = 0; m_rvalid = 0;
  endtask

  task automatic test_resp_err();
    m_arready = 1; m_rvalid = 1; m_rresp = 2'b10; m_rdata = 32'h5555_AAAA;
    tick();
    axi_addr = 32'h0000_0100; axi_rd = 1;
    tick(); axi_rd = 0;
    tick(); tick(); #1;
    m_rvalid = 0; m_rresp = 2'b00;
`ifdef DBG_AXIL_RESP_ERR_EN
    checks++; if (axi_data_out !== 32'hDEAD_BEEF || resp_err !== 1'b1) begin
      errors++; $display("FAIL err_read dout=%h err=%b exp=deadbeef/1", axi_data_out, resp_err); end
    resp_err_clr = 1;
    tick(); resp_err_clr = 0; #1;
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL err_clr got=%b exp=0", resp_err); end
    // Clear held across a DECERR write response: the set must win.
    m_awready = 1; m_wready = 1; m_bvalid = 1; m_bresp = 2'b11; resp_err_clr = 1;
    axi_addr = 32'h0000_0200; axi_data_in = 32'h1; axi_wr = 1;
    tick(); axi_wr = 0;
    tick(); tick(); #1;
    checks++; if (resp_err !== 1'b1) begin errors++; $display("FAIL err_set_wins got=%b exp=1", resp_err); end
    resp_err_clr = 0; m_bvalid = 0; m_bresp = 2'b00;
`else
    checks++; if (axi_data_out !== 32'h5555_AAAA || axi_busy !== 1'b0) begin
      errors++; $display("FAIL noerr_read dout=%h busy=%b exp=5555aaaa/0", axi_data_out, axi_busy); end
`endif
  endtask

  task automatic test_reset_mid();
    m_awready = 1; m_wready = 1; m_bvalid = 0;
    tick();
    axi_addr = 32'h4000_0030; axi_data_in = 32'h0F0F_0F0F; axi_wr = 1;
    tick(); axi_wr = 0;
    tick(); #1;
    checks++; if (m_bready !== 1'b1) begin errors++; $display("FAIL rst_in_wr_resp bready=%b exp=1", m_bready); end
    reset = 1; #1;
    checks++; if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, axi_busy} !== 6'b0) begin
      errors++; $display("FAIL rst_async got=%b exp=000000", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, axi_busy}); end
    checks++; if (m_awaddr !== 32'h0 || axi_data_out !== 32'h0) begin
      errors++; $display("FAIL rst_async_regs awaddr=%h dout=%h exp=0/0", m_awaddr, axi_data_out); end
    tick(); reset = 0;
    m_bvalid = 1;
    tick();
    axi_addr = 32'h4000_0040; axi_data_in = 32'h2468_ACE0; axi_wr = 1;
    tick(); axi_wr = 0; #1;
    checks++; if (m_awvalid !== 1'b1 || m_awaddr !== 32'h4000_0040 || m_wdata !== 32'h2468_ACE0) begin
      errors++; $display("FAIL rst_next_wr aw=%b addr=%h data=%h exp=1/40000040/2468ace0", m_awvalid, m_awaddr, m_wdata); end
    tick(); tick(); #1;
    checks++; if ({axi_busy, m_bready} !== 2'b00) begin errors++; $display("FAIL rst_next_done busy,bready=%b exp=00", {axi_busy, m_bready}); end
    m_bvalid = 0;
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_write_stall();
    test_read();
    test_wr_rd_same();
    test_resp_err();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
